acp_burst_reader: RTL and testbench
===================================

// Module: acp_burst_reader
// PURPOSE
//  Parametrised AXI4 burst read master for the ACP port of the accelerator. It fetches num_beats
//  data words from coherent memory starting at base_addr and presents them on a valid/ready
//  stream with a last flag. It splits the transfer into bursts of at most MAX_BURST beats that
//  never cross a 4 KB boundary, and raises a completion IRQ toward IRQ_F2P.
// PARAMETERS
//  ADDR_W     32       AXI address width
//  DATA_W     64       AXI/stream data width; power of 2, 32..1024
//  LEN_W      16       width of num_beats (max transfer = 2^LEN_W-1 beats)
//  MAX_BURST  16       max beats per burst; power of 2, 1..256
//  AXI_CACHE  4'b1111  driven on M_AXI_ARCACHE (ACP coherent, write-back alloc)
//  AXI_PROT   3'b000   driven on M_AXI_ARPROT
// PORTS
//  clk            in   1        bus clock (FCLK_CLK0 domain)
//  rst_n          in   1        asynchronous reset, active low
//  start          in   1        1-cycle request; sampled only in IDLE
//  base_addr      in   ADDR_W   byte address; low log2(DATA_W/8) bits forced to 0
//  num_beats      in   LEN_W    words to read; sampled with start
//  busy           out  1        high in ADDR, DATA and DONE states
//  done           out  1        1-cycle pulse at end of transfer
//  error          out  1        sticky: any RRESP!=OKAY or RLAST mismatch; cleared by accepted start
//  irq            out  1        level, set with done, cleared by irq_clr
//  irq_clr        in   1        clears irq
//  M_AXI_ARADDR   out  ADDR_W   burst address
//  M_AXI_ARLEN    out  8        beats-1
//  M_AXI_ARSIZE   out  3        log2(DATA_W/8), constant
//  M_AXI_ARBURST  out  2        2'b01 INCR, constant
//  M_AXI_ARCACHE  out  4        AXI_CACHE
//  M_AXI_ARPROT   out  3        AXI_PROT
//  M_AXI_ARVALID  out  1        address valid
//  M_AXI_ARREADY  in   1        address ready
//  M_AXI_RDATA    in   DATA_W   read data
//  M_AXI_RRESP    in   2        read response
//  M_AXI_RLAST    in   1        last beat of burst
//  M_AXI_RVALID   in   1        read valid
//  M_AXI_RREADY   out  1        read ready
//  m_tdata        out  DATA_W   stream data (= RDATA)
//  m_tvalid       out  1        stream valid
//  m_tready       in   1        stream ready
//  m_tlast        out  1        final word of whole transfer
// BEHAVIOUR
//  - Reset: state IDLE; ARVALID, RREADY, m_tvalid, m_tlast, busy, done, error and irq all 0;
//    address and length registers 0.
//  - FSM IDLE->ADDR->DATA->(ADDR|DONE)->IDLE.
//  - IDLE: start with num_beats>0 latches address and count, clears error, goes to ADDR.
//    start with num_beats==0 goes straight to DONE with no AXI traffic.
//  - ADDR: ARVALID=1 from the cycle after entry. ARADDR/ARLEN are held stable until ARREADY.
//    Burst beats = min(remaining, MAX_BURST, (4096-addr[11:0])/(DATA_W/8)).
//  - DATA: zero-latency pass-through. m_tvalid=RVALID, RREADY=m_tready, m_tdata=RDATA.
//    A beat transfers on RVALID&&m_tready. The beat counter, not RLAST, ends the burst.
//    RLAST!=(counter==ARLEN) on any beat sets error. RRESP!=0 on any beat sets error;
//    the transfer still completes.
//  - After the last beat of a burst: if remaining>0, go to ADDR with addr += beats*DATA_W/8;
//    else go to DONE. Exactly one burst is outstanding at a time.
//  - m_tlast=1 only on the final beat of the final burst.
//  - DONE: one cycle; done=1, irq<=1; then IDLE. Back-to-back start accepted the cycle after DONE.
//  - start while busy is ignored. irq set and irq_clr in the same cycle: set wins.
//  - rst_n asserted mid-transfer aborts immediately (async). The abort is legal only at system
//    reset; the interconnect is reset with it.
//  - No combinational path from M_AXI_ARREADY to any output.
// TESTING
//  1. DATA_W=64, MAX_BURST=16, base 0x1000, 40 beats -> AR 0x1000/len15, 0x1080/len15,
//     0x1100/len7; 40 stream beats in order; m_tlast only on beat 40; one done pulse.
//  2. base 0x1FE0, 10 beats -> AR 0x1FE0/len3 then 0x2000/len5; no burst crosses 0x2000.
//  3. ARREADY delayed 5 cycles, m_tready toggling 1010... -> ARADDR/ARLEN stable while ARVALID;
//     RREADY tracks m_tready; no beat lost or duplicated.
//  4. RRESP=2'b10 on beat 3 of 20 -> all 20 beats delivered; error=1 at done; next start clears it.
//  5. num_beats=0 -> ARVALID never asserted; done 1 cycle after start; irq=1 until irq_clr;
//     same-cycle set and clear leaves irq=1.
//  6. rst_n low during DATA -> ARVALID, RREADY, m_tvalid, busy and irq drop at once;
//     IDLE after release; a new 4-beat transfer completes correctly.

Source files
------------

// File: rtl/acp_burst_reader_if.sv
// AXI4 read-address/read-data channels plus the outgoing word stream of the ACP burst reader.
// The master side is the reader; the slave side is the interconnect and the stream consumer.
interface acp_burst_reader_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 64
);
   logic [ADDR_W-1:0] M_AXI_ARADDR;
   logic [7:0]        M_AXI_ARLEN;
   logic [2:0]        M_AXI_ARSIZE;
   logic [1:0]        M_AXI_ARBURST;
   logic [3:0]        M_AXI_ARCACHE;
   logic [2:0]        M_AXI_ARPROT;
   logic              M_AXI_ARVALID;
   logic              M_AXI_ARREADY;
   logic [DATA_W-1:0] M_AXI_RDATA;
   logic [1:0]        M_AXI_RRESP;
   logic              M_AXI_RLAST;
   logic              M_AXI_RVALID;
   logic              M_AXI_RREADY;
   logic [DATA_W-1:0] m_tdata;
   logic              m_tvalid;
   logic              m_tready;
   logic              m_tlast;

   modport master (
      output M_AXI_ARADDR, M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST, M_AXI_ARCACHE,
             M_AXI_ARPROT, M_AXI_ARVALID, M_AXI_RREADY, m_tdata, m_tvalid, m_tlast,
      input  M_AXI_ARREADY, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RLAST, M_AXI_RVALID, m_tready
   );

   modport slave (
      input  M_AXI_ARADDR, M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST, M_AXI_ARCACHE,
             M_AXI_ARPROT, M_AXI_ARVALID, M_AXI_RREADY, m_tdata, m_tvalid, m_tlast,
      output M_AXI_ARREADY, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RLAST, M_AXI_RVALID, m_tready
   );
endinterface

// File: rtl/acp_burst_reader.sv
// AXI4 burst read master for the ACP port: fetches num_beats words in 4 KB-safe bursts of at
// most MAX_BURST beats, streams them out with a final-word flag and raises a completion IRQ.
module acp_burst_reader #(
   parameter int         ADDR_W    = 32,
   parameter int         DATA_W    = 64,
   parameter int         LEN_W     = 16,
   parameter int         MAX_BURST = 16,
   parameter logic [3:0] AXI_CACHE = 4'b1111,
   parameter logic [2:0] AXI_PROT  = 3'b000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [LEN_W-1:0]  num_beats,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic              irq,
   input  logic              irq_clr,
   acp_burst_reader_if.master bus
);
   localparam int BYTES = DATA_W / 8;
   localparam int SIZE  = $clog2(BYTES);
   localparam int CW    = (LEN_W > 13) ? LEN_W : 13;

   typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q;
   logic [LEN_W-1:0]  remaining_q;
   logic [7:0]        arlen_q;
   logic [7:0]        cnt_q;
   logic              arvalid_q;
   logic              error_q;
   logic              irq_q;
   logic [CW-1:0]     rem_c;
   logic [CW-1:0]     page_c;
   logic [CW-1:0]     beats_c;
   logic              accept;
   logic              ar_fire;
   logic              beat;
   logic              burst_end;

   assign accept    = (state_q == IDLE) && start;
   assign ar_fire   = (state_q == ADDR) && arvalid_q && bus.M_AXI_ARREADY;
   assign beat      = (state_q == DATA) && bus.M_AXI_RVALID && bus.m_tready;
   assign burst_end = beat && (cnt_q == arlen_q);

   // Beats left before the next 4 KB page; addr_q is always word aligned.
   assign rem_c  = CW'(remaining_q);
   assign page_c = CW'((13'd4096 - {1'b0, addr_q[11:0]}) >> SIZE);

   always_comb begin
      beats_c = rem_c;
      if (beats_c > CW'(MAX_BURST)) beats_c = CW'(MAX_BURST);
      if (beats_c > page_c)         beats_c = page_c;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = (num_beats == '0) ? DONE : ADDR;
         ADDR:    if (ar_fire) state_d = DATA;
         DATA:    if (burst_end) state_d = (remaining_q == '0) ? DONE : ADDR;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // The first ADDR cycle sizes the burst; ARVALID rises from the second and holds until ARREADY.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q      <= '0;
         remaining_q <= '0;
         arlen_q     <= '0;
         cnt_q       <= '0;
         arvalid_q   <= 1'b0;
         error_q     <= 1'b0;
         irq_q       <= 1'b0;
      end else begin
         if (accept) begin
            addr_q      <= base_addr & ~ADDR_W'(BYTES - 1);
            remaining_q <= num_beats;
            error_q     <= 1'b0;
         end
         if ((state_q == ADDR) && !arvalid_q) begin
            arvalid_q <= 1'b1;
            arlen_q   <= 8'(beats_c - CW'(1));
         end
         if (ar_fire) begin
            arvalid_q   <= 1'b0;
            addr_q      <= addr_q + ((ADDR_W'(arlen_q) + ADDR_W'(1)) << SIZE);
            remaining_q <= remaining_q - (LEN_W'(arlen_q) + LEN_W'(1));
            cnt_q       <= '0;
         end
         if (beat) begin
            cnt_q <= cnt_q + 8'd1;
            if ((bus.M_AXI_RRESP != 2'b00) || (bus.M_AXI_RLAST != (cnt_q == arlen_q)))
               error_q <= 1'b1;
         end
         if (state_q == DONE)  irq_q <= 1'b1;
         else if (irq_clr)     irq_q <= 1'b0;
      end
   end

   assign bus.M_AXI_ARADDR  = addr_q;
   assign bus.M_AXI_ARLEN   = arlen_q;
   assign bus.M_AXI_ARSIZE  = 3'(SIZE);
   assign bus.M_AXI_ARBURST = 2'b01;
   assign bus.M_AXI_ARCACHE = AXI_CACHE;
   assign bus.M_AXI_ARPROT  = AXI_PROT;
   assign bus.M_AXI_ARVALID = arvalid_q;
   assign bus.M_AXI_RREADY  = (state_q == DATA) && bus.m_tready;
   assign bus.m_tdata       = bus.M_AXI_RDATA;
   assign bus.m_tvalid      = (state_q == DATA) && bus.M_AXI_RVALID;
   assign bus.m_tlast       = (state_q == DATA) && (remaining_q == '0) && (cnt_q == arlen_q);

   assign busy  = (state_q != IDLE);
   assign done  = (state_q == DONE);
   assign error = error_q;
   assign irq   = irq_q;
endmodule

// File: tb/tb_acp_burst_reader.sv
// Bench for acp_burst_reader: memory/stream responder with AR and data scoreboards,
// one task per scenario.
module tb_acp_burst_reader;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        irq_clr = 1'b0;
   logic [31:0] base_addr = '0;
   logic [15:0] num_beats = '0;
   logic        busy, done, error, irq;

   acp_burst_reader_if #(.ADDR_W(32), .DATA_W(64)) bus ();

   acp_burst_reader #(.ADDR_W(32), .DATA_W(64), .LEN_W(16), .MAX_BURST(16)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .num_beats(num_beats),
      .busy(busy), .done(done), .error(error), .irq(irq), .irq_clr(irq_clr), .bus(bus)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;
   logic [39:0] exp_ar[$];
   logic [39:0] obs_ar[$];
   logic [63:0] exp_d[$];
   bit          exp_l[$];
   int ar_delay = 0, tready_mode = 0, err_beat = -1;
   int beats_seen = 0, done_cnt = 0, arvalid_seen = 0, rbeat_idx = 0, tog = 0, arwait = 0;
   bit          b_act = 1'b0, hold_v = 1'b0;
   logic [31:0] b_addr = '0, hold_addr = '0;
   logic [7:0]  hold_len = '0;
   int          b_len = 0, b_i = 0;

   function automatic logic [63:0] data_of(input logic [31:0] a);
      return {a, ~a};
   endfunction

   // Reference split: walk beat by beat, closing a burst at 16 beats, a page edge or the end.
   task automatic model(input logic [31:0] base, input int n);
      int cnt;
      logic [31:0] a, bs;
      cnt = 0; a = base; bs = base;
      for (int i = 0; i < n; i++) begin
         if (cnt == 0) bs = a;
         exp_d.push_back(data_of(a));
         exp_l.push_back(i == n - 1);
         cnt++;
         a = a + 32'd8;
         if (cnt == 16 || a[11:0] == 12'h000 || i == n - 1) begin
            exp_ar.push_back({bs, 8'(cnt - 1)});
            cnt = 0;
         end
      end
   endtask

   // Memory and stream-sink responder; drives on the falling edge, checks 1 ns later.
   initial begin
      logic [39:0] e;
      logic [63:0] ed;
      bit el;
      bus.M_AXI_ARREADY = 1'b0; bus.M_AXI_RVALID = 1'b0; bus.M_AXI_RDATA = '0;
      bus.M_AXI_RRESP = 2'b00; bus.M_AXI_RLAST = 1'b0; bus.m_tready = 1'b0;
      forever begin
         @(negedge clk);
         tog++;
         bus.m_tready      = (tready_mode == 0) ? 1'b1 : tog[0];
         bus.M_AXI_ARREADY = bus.M_AXI_ARVALID && (arwait >= ar_delay);
         if (bus.M_AXI_ARVALID) arwait++;
         bus.M_AXI_RVALID  = b_act;
         bus.M_AXI_RDATA   = b_act ? data_of(b_addr + 32'(b_i * 8)) : '0;
         bus.M_AXI_RLAST   = b_act && (b_i == b_len);
         bus.M_AXI_RRESP   = (b_act && rbeat_idx == err_beat) ? 2'b10 : 2'b00;
         #1;
         if (!rst_n) begin
            b_act = 1'b0; hold_v = 1'b0; arwait = 0;
            continue;
         end
         if (done) done_cnt++;
         if (b_act) begin
            total++;
            if (bus.M_AXI_RREADY !== bus.m_tready || bus.m_tvalid !== 1'b1) begin
               bad++;
               $display("FAIL rready_track: rready=%b tvalid=%b required rready=%b tvalid=1",
                        bus.M_AXI_RREADY, bus.m_tvalid, bus.m_tready);
            end
            if (bus.m_tready) begin
               beats_seen++;
               total++;
               if (exp_d.size() == 0) begin
                  bad++;
                  $display("FAIL beat_extra: got data %h with no beat expected", bus.m_tdata);
               end else begin
                  ed = exp_d.pop_front();
                  el = exp_l.pop_front();
                  if (bus.m_tdata !== ed || bus.m_tlast !== el) begin
                     bad++;
                     $display("FAIL beat_data: got %h last=%b required %h last=%b",
                              bus.m_tdata, bus.m_tlast, ed, el);
                  end
               end
               b_i++;
               rbeat_idx++;
               if (b_i > b_len) b_act = 1'b0;
            end
         end
         if (bus.M_AXI_ARVALID) begin
            arvalid_seen++;
            if (hold_v) begin
               total++;
               if (bus.M_AXI_ARADDR !== hold_addr || bus.M_AXI_ARLEN !== hold_len) begin
                  bad++;
                  $display("FAIL ar_stable: got %h/%0d required %h/%0d",
                           bus.M_AXI_ARADDR, bus.M_AXI_ARLEN, hold_addr, hold_len);
               end
            end
            hold_v = 1'b1; hold_addr = bus.M_AXI_ARADDR; hold_len = bus.M_AXI_ARLEN;
            if (bus.M_AXI_ARREADY) begin
               obs_ar.push_back({bus.M_AXI_ARADDR, bus.M_AXI_ARLEN});
               total++;
               if (exp_ar.size() == 0 || b_act) begin
                  bad++;
                  $display("FAIL ar_unexpected: got %h/%0d required none (burst active=%b)",
                           bus.M_AXI_ARADDR, bus.M_AXI_ARLEN, b_act);
               end else begin
                  e = exp_ar.pop_front();
                  if ({bus.M_AXI_ARADDR, bus.M_AXI_ARLEN} !== e) begin
                     bad++;
                     $display("FAIL ar_addr_len: got %h/%0d required %h/%0d",
                              bus.M_AXI_ARADDR, bus.M_AXI_ARLEN, e[39:8], e[7:0]);
                  end
               end
               b_act = 1'b1; b_addr = bus.M_AXI_ARADDR; b_len = int'(bus.M_AXI_ARLEN);
               b_i = 0; hold_v = 1'b0; arwait = 0;
            end
         end
      end
   end

   task automatic start_xfer(input logic [31:0] base, input int n);
      @(negedge clk);
      model(base, n);
      rbeat_idx = 0;
      start = 1'b1; base_addr = base; num_beats = 16'(n);
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input int d0, input int lim, input string nm);
      int c;
      c = 0;
      while (done_cnt == d0 && c < lim) begin
         @(negedge clk); #2;
         c++;
      end
      total++;
      if (done_cnt == d0) begin
         bad++;
         $display("FAIL %s_timeout: no done after %0d cycles", nm, lim);
      end
   endtask

   task automatic check_end(input int d0, input int b0, input int n, input string nm);
      repeat (3) @(negedge clk);
      #2;
      total++;
      if (beats_seen - b0 != n || exp_d.size() != 0 || exp_ar.size() != 0) begin
         bad++;
         $display("FAIL %s_count: beats=%0d left_d=%0d left_ar=%0d required beats=%0d left 0/0",
                  nm, beats_seen - b0, exp_d.size(), exp_ar.size(), n);
      end
      total++;
      if (done_cnt != d0 + 1 || busy !== 1'b0) begin
         bad++;
         $display("FAIL %s_done: pulses=%0d busy=%b required pulses=1 busy=0",
                  nm, done_cnt - d0, busy);
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      #2;
      total++;
      if ({bus.M_AXI_ARVALID, bus.M_AXI_RREADY, bus.m_tvalid, bus.m_tlast,
           busy, done, error, irq} !== 8'h00) begin
         bad++;
         $display("FAIL reset_ctrl: got %b required 00000000",
                  {bus.M_AXI_ARVALID, bus.M_AXI_RREADY, bus.m_tvalid, bus.m_tlast,
                   busy, done, error, irq});
      end
      total++;
      if (bus.M_AXI_ARADDR !== 32'h0 || bus.M_AXI_ARLEN !== 8'h0) begin
         bad++;
         $display("FAIL reset_regs: got %h/%h required 0/0", bus.M_AXI_ARADDR, bus.M_AXI_ARLEN);
      end
      total++;
      if ({bus.M_AXI_ARSIZE, bus.M_AXI_ARBURST, bus.M_AXI_ARCACHE, bus.M_AXI_ARPROT}
          !== {3'd3, 2'b01, 4'b1111, 3'b000}) begin
         bad++;
         $display("FAIL ar_consts: size=%0d burst=%b cache=%b prot=%b required 3/01/1111/000",
                  bus.M_AXI_ARSIZE, bus.M_AXI_ARBURST, bus.M_AXI_ARCACHE, bus.M_AXI_ARPROT);
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_burst_split;
      int d0, b0;
      logic [39:0] want [3];
      want[0] = {32'h1000, 8'd15};
      want[1] = {32'h1080, 8'd15};
      want[2] = {32'h1100, 8'd7};
      ar_delay = 0; tready_mode = 0; err_beat = -1;
      obs_ar.delete();
      d0 = done_cnt; b0 = beats_seen;
      start_xfer(32'h1000, 40);
      wait_done(d0, 400, "split");
      total++;
      if (obs_ar.size() != 3) begin
         bad++;
         $display("FAIL split_nbursts: got %0d required 3", obs_ar.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            total++;
            if (obs_ar[i] !== want[i]) begin
               bad++;
               $display("FAIL split_ar%0d: got %h/%0d required %h/%0d", i,
                        obs_ar[i][39:8], obs_ar[i][7:0], want[i][39:8], want[i][7:0]);
            end
         end
      end
      check_end(d0, b0, 40, "split");
   endtask

   task automatic test_4k_boundary;
      int d0, b0;
      logic [39:0] o;
      logic [31:0] last_byte;
      obs_ar.delete();
      d0 = done_cnt; b0 = beats_seen;
      start_xfer(32'h1FE0, 10);
      wait_done(d0, 200, "page");
      total++;
      if (obs_ar.size() != 2 || obs_ar[0] !== {32'h1FE0, 8'd3} || obs_ar[1] !== {32'h2000, 8'd5}) begin
         bad++;
         $display("FAIL page_ars: got %0d bursts, first %h required 2 bursts 1fe0/3 then 2000/5",
                  obs_ar.size(), (obs_ar.size() > 0) ? obs_ar[0] : 40'h0);
      end
      foreach (obs_ar[i]) begin
         o = obs_ar[i];
         last_byte = o[39:8] + ((32'(o[7:0]) + 32'd1) * 32'd8) - 32'd1;
         total++;
         if (last_byte[31:12] !== o[39:20]) begin
            bad++;
            $display("FAIL page_cross: burst %h len %0d ends at %h", o[39:8], o[7:0], last_byte);
         end
      end
      check_end(d0, b0, 10, "page");
   endtask

   task automatic test_backpressure;
      int d0, b0;
      ar_delay = 5; tready_mode = 1;
      d0 = done_cnt; b0 = beats_seen;
      start_xfer(32'h3008, 35);
      repeat (10) @(negedge clk);
      start = 1'b1; base_addr = 32'h9000; num_beats = 16'd3;
      @(negedge clk);
      start = 1'b0;
      wait_done(d0, 2000, "bp");
      check_end(d0, b0, 35, "bp");
      ar_delay = 0; tready_mode = 0;
   endtask

   task automatic test_error_resp;
      int d0, b0;
      err_beat = 2;
      d0 = done_cnt; b0 = beats_seen;
      start_xfer(32'h4000, 20);
      wait_done(d0, 400, "err");
      total++;
      if (error !== 1'b1) begin
         bad++;
         $display("FAIL err_set: got error=%b required 1", error);
      end
      check_end(d0, b0, 20, "err");
      err_beat = -1;
      d0 = done_cnt; b0 = beats_seen;
      start_xfer(32'h5000, 4);
      total++;
      if (error !== 1'b0) begin
         bad++;
         $display("FAIL err_clear: got error=%b required 0", error);
      end
      wait_done(d0, 200, "err2");
      check_end(d0, b0, 4, "err2");
   endtask

   task automatic test_zero_len_irq;
      int d0, av0;
      @(negedge clk);
      irq_clr = 1'b1;
      @(negedge clk);
      irq_clr = 1'b0;
      #2;
      total++;
      if (irq !== 1'b0) begin
         bad++;
         $display("FAIL irq_clr: got irq=%b required 0", irq);
      end
      d0 = done_cnt; av0 = arvalid_seen;
      @(negedge clk);
      start = 1'b1; num_beats = 16'd0; base_addr = 32'h8000;
      @(negedge clk);
      start = 1'b0;
      #2;
      total++;
      if (done !== 1'b1 || busy !== 1'b1 || irq !== 1'b0) begin
         bad++;
         $display("FAIL zero_done: done=%b busy=%b irq=%b required 1/1/0", done, busy, irq);
      end
      @(negedge clk); #2;
      total++;
      if (done !== 1'b0 || busy !== 1'b0 || irq !== 1'b1) begin
         bad++;
         $display("FAIL zero_after: done=%b busy=%b irq=%b required 0/0/1", done, busy, irq);
      end
      repeat (3) @(negedge clk);
      #2;
      total++;
      if (irq !== 1'b1 || arvalid_seen != av0 || done_cnt != d0 + 1) begin
         bad++;
         $display("FAIL zero_hold: irq=%b arvalid_cycles=%0d pulses=%0d required 1/0/1",
                  irq, arvalid_seen - av0, done_cnt - d0);
      end
      @(negedge clk);
      irq_clr = 1'b1;
      @(negedge clk);
      irq_clr = 1'b0;
      @(negedge clk);
      start = 1'b1; num_beats = 16'd0;
      @(negedge clk);
      start = 1'b0;
      irq_clr = 1'b1;
      @(negedge clk);
      irq_clr = 1'b0;
      #2;
      total++;
      if (irq !== 1'b1) begin
         bad++;
         $display("FAIL irq_set_wins: got irq=%b required 1", irq);
      end
   endtask

   task automatic test_reset_abort;
      int d0, b0, c;
      b0 = beats_seen;
      start_xfer(32'h6000, 40);
      c = 0;
      while (beats_seen - b0 < 5 && c < 200) begin
         @(negedge clk); #2;
         c++;
      end
      total++;
      if (beats_seen - b0 < 5) begin
         bad++;
         $display("FAIL abort_progress: got %0d beats required at least 5", beats_seen - b0);
      end
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      total++;
      if ({bus.M_AXI_ARVALID, bus.M_AXI_RREADY, bus.m_tvalid, busy, irq} !== 5'b00000) begin
         bad++;
         $display("FAIL abort_drop: arvalid/rready/tvalid/busy/irq=%b required 00000",
                  {bus.M_AXI_ARVALID, bus.M_AXI_RREADY, bus.m_tvalid, busy, irq});
      end
      exp_d.delete(); exp_l.delete(); exp_ar.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk); #2;
      total++;
      if (busy !== 1'b0 || bus.M_AXI_ARVALID !== 1'b0) begin
         bad++;
         $display("FAIL abort_idle: busy=%b arvalid=%b required 0/0", busy, bus.M_AXI_ARVALID);
      end
      d0 = done_cnt; b0 = beats_seen;
      start_xfer(32'h7000, 4);
      wait_done(d0, 200, "after_rst");
      check_end(d0, b0, 4, "after_rst");
      total++;
      if (error !== 1'b0) begin
         bad++;
         $display("FAIL after_rst_err: got error=%b required 0", error);
      end
   endtask

   initial begin
      test_reset();
      test_burst_split();
      test_4k_boundary();
      test_backpressure();
      test_error_resp();
      test_zero_len_irq();
      test_reset_abort();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end
endmodule
